// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter in front of the memory cache.
// Only one transaction is outstanding; the response returns to the client that issued it.
module mem_arbiter #(
   parameter logic START_GRANT = 1'b0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        C0_ADDR_VALID,
   input  logic [31:0] C0_ADDR,
   input  logic        C0_DATA_VALID,
   input  logic [31:0] C0_DATA,
   output logic        C0_READY,
   output logic        C0_RESULT_VALID,
   output logic [31:0] C0_RESULT_DATA,
   input  logic        C0_RESULT_READY,
   input  logic        C1_ADDR_VALID,
   input  logic [31:0] C1_ADDR,
   input  logic        C1_DATA_VALID,
   input  logic [31:0] C1_DATA,
   output logic        C1_READY,
   output logic        C1_RESULT_VALID,
   output logic [31:0] C1_RESULT_DATA,
   input  logic        C1_RESULT_READY,
   output logic        REQ_ADDR_VALID,
   output logic [31:0] REQ_ADDR,
   output logic        REQ_DATA_VALID,
   output logic [31:0] REQ_DATA,
   input  logic        REQ_READY,
   input  logic        RESP_VALID,
   input  logic [31:0] RESP_DATA,
   output logic        RESP_READY
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t      state, next_state;
   logic        owner, last_grant, is_write;
   logic        grant0, grant1, result_hs, next_write;
   logic [31:0] result_data;

   always_ff @(posedge CLK) begin
      if (RST) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (grant0 || grant1)             next_state = S_REQ;
         S_REQ:   if (REQ_ADDR_VALID && REQ_READY) next_state = S_WAIT;
         S_WAIT:  if (RESP_VALID)                  next_state = S_RESP;
         S_RESP:  if (result_hs)                   next_state = S_IDLE;
         default:                                  next_state = S_IDLE;
      endcase
   end

   // On a tie the client that did not win last time is favoured.
   always_comb begin
      grant0     = 1'b0;
      grant1     = 1'b0;
      if (state == S_IDLE) begin
         grant0 = C0_ADDR_VALID && (!C1_ADDR_VALID || last_grant);
         grant1 = C1_ADDR_VALID && (!C0_ADDR_VALID || !last_grant);
      end
      result_hs  = (state == S_RESP) && (owner ? C1_RESULT_READY : C0_RESULT_READY);
      next_write = grant0 ? C0_DATA_VALID : (grant1 ? C1_DATA_VALID : is_write);
   end

   assign C0_READY       = grant0;
   assign C1_READY       = grant1;
   assign C0_RESULT_DATA = result_data;
   assign C1_RESULT_DATA = result_data;

   // Registered outputs are decoded from the state being entered on this edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         REQ_ADDR_VALID  <= 1'b0;
         REQ_DATA_VALID  <= 1'b0;
         RESP_READY      <= 1'b0;
         C0_RESULT_VALID <= 1'b0;
         C1_RESULT_VALID <= 1'b0;
         REQ_ADDR        <= '0;
         REQ_DATA        <= '0;
         result_data     <= '0;
         is_write        <= 1'b0;
         owner           <= 1'b0;
         last_grant      <= ~START_GRANT;
      end else begin
         REQ_ADDR_VALID  <= (next_state == S_REQ);
         REQ_DATA_VALID  <= (next_state == S_REQ) && next_write;
         RESP_READY      <= (next_state == S_WAIT);
         C0_RESULT_VALID <= (next_state == S_RESP) && !owner;
         C1_RESULT_VALID <= (next_state == S_RESP) && owner;
         is_write        <= next_write;
         if (grant0) begin
            REQ_ADDR <= C0_ADDR;
            REQ_DATA <= C0_DATA;
            owner    <= 1'b0;
         end else if (grant1) begin
            REQ_ADDR <= C1_ADDR;
            REQ_DATA <= C1_DATA;
            owner    <= 1'b1;
         end
         if (state == S_WAIT && RESP_VALID) result_data <= RESP_DATA;
         if (result_hs) last_grant <= owner;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand sequences and random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

   localparam logic SG = 1'b0;

   logic        CLK = 1'b0;
   logic        RST;
   logic        c0v, c0dv, c1v, c1dv, rr0, rr1, req_ready, resp_valid;
   logic [31:0] c0a, c0d, c1a, c1d, resp_data;
   logic        C0_READY, C1_READY, C0_RESULT_VALID, C1_RESULT_VALID;
   logic        REQ_ADDR_VALID, REQ_DATA_VALID, RESP_READY;
   logic [31:0] C0_RESULT_DATA, C1_RESULT_DATA, REQ_ADDR, REQ_DATA;

   int n_vec = 0;
   int n_err = 0;

   mem_arbiter #(.START_GRANT(SG)) dut (
      .CLK(CLK), .RST(RST),
      .C0_ADDR_VALID(c0v), .C0_ADDR(c0a), .C0_DATA_VALID(c0dv), .C0_DATA(c0d),
      .C0_READY(C0_READY), .C0_RESULT_VALID(C0_RESULT_VALID),
      .C0_RESULT_DATA(C0_RESULT_DATA), .C0_RESULT_READY(rr0),
      .C1_ADDR_VALID(c1v), .C1_ADDR(c1a), .C1_DATA_VALID(c1dv), .C1_DATA(c1d),
      .C1_READY(C1_READY), .C1_RESULT_VALID(C1_RESULT_VALID),
      .C1_RESULT_DATA(C1_RESULT_DATA), .C1_RESULT_READY(rr1),
      .REQ_ADDR_VALID(REQ_ADDR_VALID), .REQ_ADDR(REQ_ADDR),
      .REQ_DATA_VALID(REQ_DATA_VALID), .REQ_DATA(REQ_DATA), .REQ_READY(req_ready),
      .RESP_VALID(resp_valid), .RESP_DATA(resp_data), .RESP_READY(RESP_READY)
   );

   always #5 CLK = ~CLK;

   // Reference model: progress of the single outstanding transaction
   // (0 none, 1 offered to cache, 2 awaiting cache data, 3 result offered to client).
   int          ph;
   bit          m_own, m_last, m_wr, z_req, z_res, g0, g1;
   logic [31:0] m_addr, m_data, m_res;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      ph = 0; m_own = 0; m_last = ~SG; m_wr = 0;
      m_addr = '0; m_data = '0; m_res = '0; z_req = 1; z_res = 1;
   endtask

   // Called at posedge+1 with inputs driven; checks at negedge, advances model, returns at posedge+1.
   task automatic step();
      bit e0, e1;
      @(negedge CLK);
      e0 = (ph == 0) && c0v && (!c1v || m_last);
      e1 = (ph == 0) && c1v && (!c0v || !m_last);
      chk("C0_READY", C0_READY, e0);
      chk("C1_READY", C1_READY, e1);
      chk("REQ_ADDR_VALID", REQ_ADDR_VALID, ph == 1);
      chk("REQ_DATA_VALID", REQ_DATA_VALID, ph == 1 && m_wr);
      chk("RESP_READY", RESP_READY, ph == 2);
      chk("C0_RESULT_VALID", C0_RESULT_VALID, ph == 3 && !m_own);
      chk("C1_RESULT_VALID", C1_RESULT_VALID, ph == 3 && m_own);
      if (ph == 1 || z_req) begin
         chk("REQ_ADDR", REQ_ADDR, m_addr);
         chk("REQ_DATA", REQ_DATA, m_data);
      end
      if (ph == 3) chk("RESULT_DATA", m_own ? C1_RESULT_DATA : C0_RESULT_DATA, m_res);
      if (z_res) begin
         chk("C0_RESULT_DATA_rst", C0_RESULT_DATA, '0);
         chk("C1_RESULT_DATA_rst", C1_RESULT_DATA, '0);
      end
      g0 = 0; g1 = 0;
      if (RST) model_reset();
      else if (ph == 0) begin
         if (e0) begin g0 = 1; m_own = 0; m_addr = c0a; m_data = c0d; m_wr = c0dv; end
         if (e1) begin g1 = 1; m_own = 1; m_addr = c1a; m_data = c1d; m_wr = c1dv; end
         if (e0 || e1) begin ph = 1; z_req = 0; end
      end else if (ph == 1) begin
         if (req_ready) ph = 2;
      end else if (ph == 2) begin
         if (resp_valid) begin ph = 3; m_res = resp_data; z_res = 0; end
      end else if (m_own ? rr1 : rr0) begin
         ph = 0; m_last = m_own;
      end
      @(posedge CLK); #1;
   endtask

   task automatic idle_inputs();
      RST = 0; c0v = 0; c1v = 0; c0dv = 0; c1dv = 0; rr0 = 0; rr1 = 0;
      req_ready = 0; resp_valid = 0; c0a = '0; c0d = '0; c1a = '0; c1d = '0; resp_data = '0;
   endtask

   task automatic do_reset();
      idle_inputs(); RST = 1; step(); RST = 0;
   endtask

   task automatic finish_txn(input logic [31:0] d);
      req_ready = 1; step(); req_ready = 0;
      resp_valid = 1; resp_data = d; step(); resp_valid = 0;
      rr0 = 1; rr1 = 1; step(); rr0 = 0; rr1 = 0;
   endtask

   typedef struct {
      bit rst, v0, v1, w0, w1;
      logic [31:0] a0, d0, a1, d1, rsp;
      bit exp_win, exp_wr;
      logic [31:0] exp_addr, exp_data, exp_res;
   } vec_t;

   vec_t vt[7];

   task automatic run_row(input vec_t v);
      if (v.rst) do_reset();
      c0v = v.v0; c0dv = v.w0; c0a = v.a0; c0d = v.d0;
      c1v = v.v1; c1dv = v.w1; c1a = v.a1; c1d = v.d1;
      #3;
      chk("row_C0_READY", C0_READY, !v.exp_win);
      chk("row_C1_READY", C1_READY, v.exp_win);
      step();
      c0v = 0; c1v = 0; req_ready = 1;
      #3;
      chk("row_REQ_ADDR", REQ_ADDR, v.exp_addr);
      chk("row_REQ_DATA", REQ_DATA, v.exp_data);
      chk("row_REQ_DATA_VALID", REQ_DATA_VALID, v.exp_wr);
      step();
      req_ready = 0; resp_valid = 1; resp_data = v.rsp;
      step();
      resp_valid = 0; rr0 = 1; rr1 = 1;
      #3;
      chk("row_win_RESULT_VALID", v.exp_win ? C1_RESULT_VALID : C0_RESULT_VALID, 1);
      chk("row_lose_RESULT_VALID", v.exp_win ? C0_RESULT_VALID : C1_RESULT_VALID, 0);
      chk("row_RESULT_DATA", v.exp_win ? C1_RESULT_DATA : C0_RESULT_DATA, v.exp_res);
      step();
      rr0 = 0; rr1 = 0;
   endtask

   bit          pend[2], rw[2];
   logic [31:0] ra[2], rd[2];

   initial begin
      //        rst v0 v1 w0 w1  a0            d0            a1            d1            rsp           win wr addr          data          res
      vt[0] = '{1, 1, 0, 0, 0, 32'h0000_0100, 32'hA5A5_0000, 32'h0,        32'h0,        32'hDEAD_BEEF, 0, 0, 32'h0000_0100, 32'hA5A5_0000, 32'hDEAD_BEEF};
      vt[1] = '{1, 0, 1, 0, 1, 32'h0,        32'h0,        32'h0000_0200, 32'h1234_5678, 32'h1234_5678, 1, 1, 32'h0000_0200, 32'h1234_5678, 32'h1234_5678};
      vt[2] = '{1, 1, 1, 0, 1, 32'h0000_0300, 32'h0000_0011, 32'h0000_0400, 32'h0000_0022, 32'hCAFE_0001, 0, 0, 32'h0000_0300, 32'h0000_0011, 32'hCAFE_0001};
      vt[3] = '{0, 0, 1, 0, 1, 32'h0,        32'h0,        32'h0000_0400, 32'h0000_0022, 32'h0000_0022, 1, 1, 32'h0000_0400, 32'h0000_0022, 32'h0000_0022};
      vt[4] = '{0, 1, 1, 1, 0, 32'h0000_0500, 32'h0000_0033, 32'h0000_0600, 32'h0000_0044, 32'h0000_0033, 0, 1, 32'h0000_0500, 32'h0000_0033, 32'h0000_0033};
      vt[5] = '{0, 1, 1, 0, 0, 32'h0000_0700, 32'h0000_0055, 32'h0000_0800, 32'h0000_0066, 32'hFFFF_FFFF, 1, 0, 32'h0000_0800, 32'h0000_0066, 32'hFFFF_FFFF};
      vt[6] = '{0, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 32'hFFFF_FFFC, 32'h0,        32'h0};

      model_reset();
      idle_inputs();
      RST = 1;
      @(posedge CLK); #1;
      step();
      RST = 0;

      foreach (vt[i]) run_row(vt[i]);

      // Backpressure on both sides while C1 keeps requesting.
      do_reset();
      c0v = 1; c0dv = 1; c0a = 32'h0000_0A00; c0d = 32'h0BAD_F00D;
      c1v = 1; c1dv = 0; c1a = 32'h0000_0B00; c1d = 32'h0000_0001;
      step();
      c0v = 0;
      repeat (5) step();
      req_ready = 1; step(); req_ready = 0;
      resp_valid = 1; resp_data = 32'h0BAD_F00D; step(); resp_valid = 0;
      repeat (4) step();
      rr0 = 1; step(); rr0 = 0;
      step();
      c1v = 0;
      finish_txn(32'h7777_0000);

      // Reset while waiting for the cache, then a normal C1 read.
      c0v = 1; c0dv = 0; c0a = 32'h0000_0C00; c0d = 32'h0000_00C0; step(); c0v = 0;
      req_ready = 1; step(); req_ready = 0;
      step();
      RST = 1; step(); RST = 0;
      step();
      c1v = 1; c1dv = 0; c1a = 32'h0000_0D00; step(); c1v = 0;
      finish_txn(32'h1234_ABCD);

      // Stray cache responses outside the wait phase.
      resp_valid = 1; resp_data = 32'hBADB_AD00;
      repeat (2) step();
      c0v = 1; c0a = 32'h0000_0E00; c0d = 32'h0000_00E0; step(); c0v = 0;
      step();
      resp_valid = 0;
      finish_txn(32'h5A5A_5A5A);

      // Random traffic.
      do_reset();
      pend[0] = 0; pend[1] = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         for (int n = 0; n < 2; n++) begin
            if (!pend[n] && !(ph != 0 && m_own == n) && $urandom_range(0, 2) == 0) begin
               pend[n] = 1; ra[n] = $urandom; rd[n] = $urandom; rw[n] = 1'($urandom_range(0, 1));
            end
         end
         c0v = pend[0]; c0a = ra[0]; c0d = rd[0]; c0dv = rw[0];
         c1v = pend[1]; c1a = ra[1]; c1d = rd[1]; c1dv = rw[1];
         req_ready  = 1'($urandom_range(0, 1));
         resp_valid = ($urandom_range(0, 2) == 0);
         resp_data  = (ph == 2 && m_wr) ? m_data : $urandom;
         rr0 = 1'($urandom_range(0, 1));
         rr1 = 1'($urandom_range(0, 1));
         RST = ($urandom_range(0, 299) == 0);
         step();
         if (g0) pend[0] = 0;
         if (g1) pend[1] = 0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
